fetch_prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch queue between instruction_mem and decode_block.

---
 rtl/fetch_prefetch_queue_pkg.sv | 17 +
 rtl/fetch_prefetch_queue_storage.sv | 26 ++
 rtl/fetch_prefetch_queue.sv | 92 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared widths, entry type and pointer helper for the instruction prefetch queue.
package fetch_prefetch_queue_pkg;

   localparam int unsigned HALF_WORD = 16;
   localparam int unsigned WORD      = 32;

   typedef struct packed {
      logic [HALF_WORD-1:0] instr;
      logic [WORD-1:0]      pc;
   } fetch_entry_t;

   // Circular increment for queues whose depth need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fetch_prefetch_queue_storage.sv
// Entry array for the prefetch queue: one write port, asynchronous read, data never reset.
module fetch_prefetch_queue_storage #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 48,
   parameter int unsigned PTR_W  = 2
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      always_ff @(posedge clk_i) begin
         if (we_i && (waddr_i == PTR_W'(e)))
            mem[e] <= wdata_i;
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode with flush, stall hold and optional empty bypass.
module fetch_prefetch_queue
   import fetch_prefetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned INSTR_W = HALF_WORD,
   parameter int unsigned PC_W    = WORD,
   parameter int unsigned BYPASS  = 1,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               flush_pipeline_i,
   input  logic               stall_pipeline_i,
   input  logic               is_valid_i,
   input  logic [INSTR_W-1:0] instruction_i,
   input  logic [PC_W-1:0]    program_counter_i,
   output logic               ready_o,
   output logic               is_valid_o,
   output logic [INSTR_W-1:0] instruction_o,
   output logic [PC_W-1:0]    program_counter_o,
   output logic [CNT_W-1:0]   count_o
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned ENTRY_W = INSTR_W + PC_W;

   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [ENTRY_W-1:0] rd_data;
   logic               empty, byp_act;
   logic               push, pop, byp_hit, push_st, pop_st;

   assign empty   = (count_o == '0);
   // Registered-only so the upstream PC enable never loops through decode stall.
   assign ready_o = (count_o < CNT_W'(DEPTH));
   assign byp_act = (BYPASS != 0) && empty && is_valid_i;

   assign is_valid_o = ~flush_pipeline_i & (~empty | byp_act);

   always_comb begin
      instruction_o     = '0;
      program_counter_o = '0;
      if (!empty) begin
         instruction_o     = rd_data[ENTRY_W-1:PC_W];
         program_counter_o = rd_data[PC_W-1:0];
      end else if (byp_act) begin
         instruction_o     = instruction_i;
         program_counter_o = program_counter_i;
      end
   end

   assign push    = is_valid_i & ready_o & ~flush_pipeline_i;
   assign pop     = is_valid_o & ~stall_pipeline_i & ~flush_pipeline_i;
   // A word that decode consumes straight off the input never touches storage.
   assign byp_hit = byp_act & push & pop;
   assign push_st = push & ~byp_hit;
   assign pop_st  = pop & ~empty;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else if (flush_pipeline_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push_st) wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
         if (pop_st)  rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
         case ({push_st, pop_st})
            2'b10:   count_o <= count_o + CNT_W'(1);
            2'b01:   count_o <= count_o - CNT_W'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   fetch_prefetch_queue_storage #(
      .DEPTH  (DEPTH),
      .DATA_W (ENTRY_W),
      .PTR_W  (PTR_W)
   ) u_storage (
      .clk_i   (clk_i),
      .we_i    (push_st),
      .waddr_i (wr_ptr),
      .wdata_i ({instruction_i, program_counter_i}),
      .raddr_i (rd_ptr),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: DEPTH=4 bypass, DEPTH=3 wrap, and DEPTH=4 no-bypass instances.
module tb_fetch_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] instr = '0;
   logic [31:0] pc = '0;
   logic        vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;

   logic        rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
   logic [15:0] in_a, in_b, in_c;
   logic [31:0] pc_a, pc_b, pc_c;
   logic [2:0]  cnt_a, cnt_c;
   logic [1:0]  cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(.DEPTH(4), .BYPASS(1)) u_dut_a (
      .clk_i(clk), .reset_i(reset), .flush_pipeline_i(flush), .stall_pipeline_i(stall),
      .is_valid_i(vld_a), .instruction_i(instr), .program_counter_i(pc),
      .ready_o(rdy_a), .is_valid_o(ov_a), .instruction_o(in_a), .program_counter_o(pc_a),
      .count_o(cnt_a));

   fetch_prefetch_queue #(.DEPTH(3), .BYPASS(1)) u_dut_b (
      .clk_i(clk), .reset_i(reset), .flush_pipeline_i(flush), .stall_pipeline_i(stall),
      .is_valid_i(vld_b), .instruction_i(instr), .program_counter_i(pc),
      .ready_o(rdy_b), .is_valid_o(ov_b), .instruction_o(in_b), .program_counter_o(pc_b),
      .count_o(cnt_b));

   fetch_prefetch_queue #(.DEPTH(4), .BYPASS(0)) u_dut_c (
      .clk_i(clk), .reset_i(reset), .flush_pipeline_i(flush), .stall_pipeline_i(stall),
      .is_valid_i(vld_c), .instruction_i(instr), .program_counter_i(pc),
      .ready_o(rdy_c), .is_valid_o(ov_c), .instruction_o(in_c), .program_counter_o(pc_c),
      .count_o(cnt_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (cnt_a !== 3'd0 || rdy_a !== 1'b1 || ov_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: cnt=%0d rdy=%b vld=%b, want 0 1 0", cnt_a, rdy_a, ov_a);
      end
      checks++;
      if (in_a !== 16'h0 || pc_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: instr=%h pc=%h, want 0 0", in_a, pc_a);
      end
      checks++;
      if (cnt_c !== 3'd0 || ov_c !== 1'b0 || cnt_b !== 2'd0) begin
         errors++;
         $display("FAIL reset_bc: cnt_b=%0d cnt_c=%0d vld_c=%b, want 0 0 0", cnt_b, cnt_c, ov_c);
      end
   endtask

   task automatic test_bypass();
      vld_a = 1'b1; pc = 32'h10; instr = 16'h2001; stall = 1'b0;
      #1;
      checks++;
      if (ov_a !== 1'b1 || pc_a !== 32'h10 || in_a !== 16'h2001) begin
         errors++;
         $display("FAIL bypass_comb: vld=%b pc=%h instr=%h, want 1 10 2001", ov_a, pc_a, in_a);
      end
      tick();
      checks++;
      if (cnt_a !== 3'd0) begin
         errors++;
         $display("FAIL bypass_count: cnt=%0d, want 0", cnt_a);
      end
      vld_a = 1'b0;
   endtask

   task automatic test_fill_drain();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         vld_a = 1'b1; pc = 32'h20 + 32'(2 * i); instr = 16'hA000 | 16'(pc);
         tick();
         if (i == 3) begin
            checks++;
            if (cnt_a !== 3'd4 || rdy_a !== 1'b0) begin
               errors++;
               $display("FAIL fill_full: cnt=%0d rdy=%b, want 4 0", cnt_a, rdy_a);
            end
         end
      end
      vld_a = 1'b0;
      checks++;
      if (cnt_a !== 3'd4 || pc_a !== 32'h20) begin
         errors++;
         $display("FAIL fill_drop: cnt=%0d head=%h, want 4 20", cnt_a, pc_a);
      end
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ov_a !== 1'b1 || pc_a !== 32'h20 + 32'(2 * i) || in_a !== (16'hA020 + 16'(2 * i))) begin
            errors++;
            $display("FAIL drain_%0d: vld=%b pc=%h instr=%h, want 1 %h %h", i, ov_a, pc_a, in_a,
                     32'h20 + 32'(2 * i), 16'hA020 + 16'(2 * i));
         end
         tick();
      end
      checks++;
      if (cnt_a !== 3'd0 || ov_a !== 1'b0 || rdy_a !== 1'b1) begin
         errors++;
         $display("FAIL drain_empty: cnt=%0d vld=%b rdy=%b, want 0 0 1", cnt_a, ov_a, rdy_a);
      end
   endtask

   task automatic test_flush();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vld_a = 1'b1; pc = 32'h30 + 32'(2 * i); instr = 16'h3000 + 16'(i);
         tick();
      end
      flush = 1'b1; vld_a = 1'b1; pc = 32'h99; stall = 1'b0;
      #1;
      checks++;
      if (ov_a !== 1'b0 || cnt_a !== 3'd3) begin
         errors++;
         $display("FAIL flush_comb: vld=%b cnt=%0d, want 0 3", ov_a, cnt_a);
      end
      tick();
      checks++;
      if (cnt_a !== 3'd0) begin
         errors++;
         $display("FAIL flush_count: cnt=%0d, want 0", cnt_a);
      end
      flush = 1'b0; vld_a = 1'b1; pc = 32'h100; instr = 16'h4100; stall = 1'b1;
      tick();
      vld_a = 1'b0;
      checks++;
      if (cnt_a !== 3'd1 || ov_a !== 1'b1 || pc_a !== 32'h100 || in_a !== 16'h4100) begin
         errors++;
         $display("FAIL flush_target: cnt=%0d vld=%b pc=%h instr=%h, want 1 1 100 4100",
                  cnt_a, ov_a, pc_a, in_a);
      end
      stall = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      int bad = 0;
      stall = 1'b1; vld_b = 1'b1; pc = 32'h0; instr = 16'h5000;
      tick();
      stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pc = 32'(2 * (i + 1)); instr = 16'h5000 + 16'(i + 1);
         #1;
         if (ov_b !== 1'b1 || pc_b !== 32'(2 * i) || in_b !== 16'h5000 + 16'(i)) bad++;
         tick();
         if (cnt_b !== 2'd1) bad++;
      end
      vld_b = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_order: %0d bad steps, want 0", bad);
      end
      #1;
      checks++;
      if (pc_b !== 32'h14 || cnt_b !== 2'd1) begin
         errors++;
         $display("FAIL wrap_tail: head=%h cnt=%0d, want 14 1", pc_b, cnt_b);
      end
      tick();
      checks++;
      if (cnt_b !== 2'd0) begin
         errors++;
         $display("FAIL wrap_drain: cnt=%0d, want 0", cnt_b);
      end
   endtask

   task automatic test_async_reset();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vld_a = 1'b1; pc = 32'h60 + 32'(2 * i); instr = 16'h6000;
         tick();
      end
      vld_a = 1'b0;
      checks++;
      if (cnt_a !== 3'd2) begin
         errors++;
         $display("FAIL areset_pre: cnt=%0d, want 2", cnt_a);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (cnt_a !== 3'd0 || ov_a !== 1'b0 || rdy_a !== 1'b1 || pc_a !== 32'h0) begin
         errors++;
         $display("FAIL areset_clear: cnt=%0d vld=%b rdy=%b pc=%h, want 0 0 1 0",
                  cnt_a, ov_a, rdy_a, pc_a);
      end
      tick();
      reset = 1'b0; stall = 1'b0;
      tick();
   endtask

   task automatic test_no_bypass();
      vld_c = 1'b1; pc = 32'h40; instr = 16'h7040; stall = 1'b0;
      #1;
      checks++;
      if (ov_c !== 1'b0) begin
         errors++;
         $display("FAIL nobyp_same: vld=%b, want 0", ov_c);
      end
      tick();
      vld_c = 1'b0;
      #1;
      checks++;
      if (ov_c !== 1'b1 || pc_c !== 32'h40 || in_c !== 16'h7040 || cnt_c !== 3'd1) begin
         errors++;
         $display("FAIL nobyp_next: vld=%b pc=%h instr=%h cnt=%0d, want 1 40 7040 1",
                  ov_c, pc_c, in_c, cnt_c);
      end
      tick();
      checks++;
      if (ov_c !== 1'b0 || cnt_c !== 3'd0) begin
         errors++;
         $display("FAIL nobyp_after: vld=%b cnt=%0d, want 0 0", ov_c, cnt_c);
      end
   endtask

   initial begin
      #12 reset = 1'b0;
      tick();
      test_reset();
      test_bypass();
      test_fill_drain();
      test_flush();
      test_wrap();
      test_async_reset();
      test_no_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
